simple_cpu8: RTL and testbench



---
 rtl/simple_cpu8.sv | 128 ++++++++++++
 tb/tb_simple_cpu8.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/simple_cpu8.sv
// ---------------------------------------------------------------------------
// simple_cpu8 -- single-cycle 8-bit processor core.
//
// Each clock executes one instruction. The instruction is fetched by the
// surrounding system at address PC and arrives combinationally. The core
// decodes it, reads two operands from an 8x8 register file, runs the ALU and
// writes the result back to Rd at the next rising edge. PC advances by 4 on
// every edge that is not a reset edge.
//
// Ports:
//   CLK          in   1   clock, all state updates on the rising edge
//   RESET        in   1   synchronous active-high reset (PC and registers to 0)
//   INSTRUCTION  in  32   instruction at address PC
//   PC           out 32   registered program counter
//   ALURESULT    out  8   combinational ALU output (register write data)
//
// Instruction fields: OPCODE[31:24], Rd[18:16], Rt[10:8], Rs[2:0], IMM[7:0].
// ---------------------------------------------------------------------------
module simple_cpu8 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic [7:0]  ALURESULT
);

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

    // Two's-complement negation, 8-bit wrap: negating 0x80 yields 0x80.
    function automatic logic [7:0] negate8(input logic [7:0] v);
        return ~v + 8'd1;
    endfunction

    // Select values 100-111 are reserved and produce zero.
    function automatic logic [7:0] alu8(input logic [2:0]  sel,
                                        input logic [7:0]  d1,
                                        input logic [7:0]  d2);
        case (sel)
            ALU_FWD: return d2;
            ALU_ADD: return d1 + d2;
            ALU_AND: return d1 & d2;
            ALU_OR:  return d1 | d2;
            default: return 8'h00;
        endcase
    endfunction

    // Instruction fields
    logic [7:0] opcode;
    logic [2:0] rd;
    logic [2:0] rt;
    logic [2:0] rs;
    logic [7:0] imm;
    logic       unused_bits;

    assign opcode      = INSTRUCTION[31:24];
    assign rd          = INSTRUCTION[18:16];
    assign rt          = INSTRUCTION[10:8];
    assign rs          = INSTRUCTION[2:0];
    assign imm         = INSTRUCTION[7:0];
    assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    // State
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [7:0]  regs_q [8];

    // Decode
    logic    wr_en;
    logic    neg_sel;
    logic    imm_sel;
    alu_op_e alu_op;

    always_comb begin
        wr_en   = 1'b0;
        neg_sel = 1'b0;
        imm_sel = 1'b0;
        alu_op  = ALU_FWD;
        case (opcode)
            8'h00: begin wr_en = 1'b1; imm_sel = 1'b1; end
            8'h01: begin wr_en = 1'b1; end
            8'h02: begin wr_en = 1'b1; alu_op = ALU_ADD; end
            8'h03: begin wr_en = 1'b1; alu_op = ALU_ADD; neg_sel = 1'b1; end
            8'h04: begin wr_en = 1'b1; alu_op = ALU_AND; end
            8'h05: begin wr_en = 1'b1; alu_op = ALU_OR; end
            default: ;
        endcase
    end

    // Operand path: reg[Rs] -> optional negation -> optional immediate override
    logic [7:0] rdata1;
    logic [7:0] rdata2;
    logic [7:0] op2_neg;
    logic [7:0] data2;
    logic [7:0] alu_result;

    assign rdata1     = regs_q[rt];
    assign rdata2     = regs_q[rs];
    assign op2_neg    = neg_sel ? negate8(rdata2) : rdata2;
    assign data2      = imm_sel ? imm : op2_neg;
    assign alu_result = alu8(alu_op, rdata1, data2);

    assign pc_d = pc_q + 32'd4;

    // Reads above see pre-edge register values, so Rd == Rt/Rs uses the old
    // operand; reset wins over the write-back of the current instruction.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= 32'h0000_0000;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            pc_q <= pc_d;
            if (wr_en) begin
                regs_q[rd] <= alu_result;
            end
        end
    end

    assign PC        = pc_q;
    assign ALURESULT = alu_result;

endmodule

// File: tb/tb_simple_cpu8.sv
module tb_simple_cpu8;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [7:0]  ALURESULT;

    int n_cmp;
    int n_bad;

    simple_cpu8 dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .ALURESULT   (ALURESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Architectural model: register array, program counter, validity flag
    logic [7:0]  m_regs [8];
    logic [31:0] m_pc;
    bit          m_valid;

    initial m_valid = 1'b0;

    // Result an instruction must produce, written from the opcode table
    function automatic logic [7:0] model_result(input logic [31:0] ins);
        logic [7:0] a;
        logic [7:0] b;
        a = m_regs[ins[10:8]];
        b = m_regs[ins[2:0]];
        case (ins[31:24])
            8'h00:   return ins[7:0];
            8'h01:   return b;
            8'h02:   return 8'((int'(a) + int'(b)) % 256);
            8'h03:   return 8'((int'(a) - int'(b) + 256) % 256);
            8'h04:   return a & b;
            8'h05:   return a | b;
            default: return b;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            m_pc    <= 32'd0;
            m_valid <= 1'b1;
            for (int i = 0; i < 8; i++) m_regs[i] <= 8'h00;
        end else if (m_valid) begin
            m_pc <= m_pc + 32'd4;
            if (INSTRUCTION[31:24] <= 8'h05)
                m_regs[INSTRUCTION[18:16]] <= model_result(INSTRUCTION);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (m_valid) begin
            n_cmp++;
            if (PC !== m_pc) begin
                n_bad++;
                $display("FAIL model_pc t=%0t ins=%08h actual=%08h expected=%08h",
                         $time, INSTRUCTION, PC, m_pc);
            end
            n_cmp++;
            if (ALURESULT !== model_result(INSTRUCTION)) begin
                n_bad++;
                $display("FAIL model_alu t=%0t ins=%08h actual=%02h expected=%02h",
                         $time, INSTRUCTION, ALURESULT, model_result(INSTRUCTION));
            end
        end
    end

    // Hand-computed literal checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Present an instruction just after a rising edge, return at the falling edge
    task automatic apply(input logic [31:0] ins, input logic rst);
        @(posedge CLK);
        #1;
        INSTRUCTION = ins;
        RESET       = rst;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] pc_prev;
        int          r;
        n_cmp       = 0;
        n_bad       = 0;
        RESET       = 1'b1;
        INSTRUCTION = $urandom;

        // Reset with arbitrary instructions
        apply($urandom, 1'b1);
        apply($urandom, 1'b1);
        apply(32'h0100_0003, 1'b0);           // mov r0,r3
        check("reset_pc", PC, 32'h0);
        check("reset_regs", {24'd0, ALURESULT}, 32'h00);

        // Basic program: mov above runs at PC 0
        apply(32'h0001_0005, 1'b0);           // loadi r1,0x05
        check("loadi_r1", {24'd0, ALURESULT}, 32'h05);
        check("pc_after_mov", PC, 32'h4);
        apply(32'h0002_0003, 1'b0);           // loadi r2,0x03
        check("loadi_r2", {24'd0, ALURESULT}, 32'h03);
        apply(32'h0203_0102, 1'b0);           // add r3,r1,r2
        check("add_5_3", {24'd0, ALURESULT}, 32'h08);
        apply(32'h0304_0201, 1'b0);           // sub r4,r2,r1
        check("sub_3_5", {24'd0, ALURESULT}, 32'hFE);
        check("pc_at_sub", PC, 32'h10);
        apply(32'h0100_0004, 1'b0);           // mov r0,r4
        check("r4_written", {24'd0, ALURESULT}, 32'hFE);
        check("pc_after_sub", PC, 32'h14);

        // Logic ops and wrapping add
        apply(32'h0001_00F0, 1'b0);           // loadi r1,0xF0
        apply(32'h0002_003C, 1'b0);           // loadi r2,0x3C
        apply(32'h0405_0102, 1'b0);           // and r5,r1,r2
        check("and_f0_3c", {24'd0, ALURESULT}, 32'h30);
        apply(32'h0506_0102, 1'b0);           // or r6,r1,r2
        check("or_f0_3c", {24'd0, ALURESULT}, 32'hFC);
        apply(32'h0002_0020, 1'b0);           // loadi r2,0x20
        apply(32'h0207_0102, 1'b0);           // add r7,r1,r2
        check("add_wrap", {24'd0, ALURESULT}, 32'h10);

        // Negating 0x80 stays 0x80: 0 - 0x80 = 0x80
        apply(32'h0003_0080, 1'b0);           // loadi r3,0x80
        apply(32'h0302_0003, 1'b0);           // sub r2,r0,r3 (r0 = 0xFE)
        check("sub_neg80", {24'd0, ALURESULT}, 32'h7E);

        // Undefined opcode leaves r1 alone, PC still advances
        apply(32'h0701_0F00, 1'b0);
        pc_prev = PC;
        apply(32'h0100_0001, 1'b0);           // mov r0,r1
        check("bad_op_no_write", {24'd0, ALURESULT}, 32'hF0);
        check("bad_op_pc", PC, pc_prev + 32'd4);

        // Reset in the same cycle as a write aborts the write
        apply(32'h0005_00AA, 1'b1);           // loadi r5,0xAA with RESET
        apply(32'h0100_0005, 1'b0);           // mov r0,r5
        check("reset_abort_write", {24'd0, ALURESULT}, 32'h00);
        check("reset_abort_pc", PC, 32'h0);

        // In-place update
        apply(32'h0001_0081, 1'b0);           // loadi r1,0x81
        apply(32'h0201_0101, 1'b0);           // add r1,r1,r1
        check("inplace_add", {24'd0, ALURESULT}, 32'h02);
        apply(32'h0100_0001, 1'b0);           // mov r0,r1
        check("inplace_read", {24'd0, ALURESULT}, 32'h02);

        // Randomized instruction stream, occasional reset
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            r   = $urandom_range(0, 9);
            if (r <= 7) ins[31:24] = 8'(r);
            else        ins[31:24] = 8'($urandom_range(0, 255));
            apply(ins, ($urandom_range(0, 39) == 0));
        end

        apply(32'h0100_0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
